// File: rtl/status_led_pkg.sv
// Shared types and constants for the status LED driver.
// Optional feature macro: STATUS_LED_PWM_EN (idle-on PWM dimming).
package status_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF
    } led_state_t;

    // Width of the free-running PWM counter (sixteen duty steps).
    localparam int unsigned PWM_CNT_W = 4;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/status_led_driver_tick_prescaler.sv
// Free-running prescaler: pulses tick for one cycle every PRESCALE cycles.
// Optional feature macro: STATUS_LED_PWM_EN (not used in this file).
import status_led_pkg::*;

module tick_prescaler #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic clk,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = cnt_width(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    // Count 0..PRESCALE-1 and wrap; clear restarts the period at 0.
    always_ff @(posedge clk) begin
        if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/status_led_driver.sv
// Status LED driver: blinks an acknowledge sequence on every status change,
// otherwise shows the status level.
// Optional feature macro: STATUS_LED_PWM_EN (dims the idle-on level by PWM).
import status_led_pkg::*;

module status_led_driver #(
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned BLINK_TICKS = 100,
    parameter int unsigned BLINK_COUNT = 3,
    parameter int unsigned PWM_DUTY    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic status,
    output logic led,
    output logic busy
);

    localparam int unsigned TICK_W  = cnt_width(BLINK_TICKS);
    localparam int unsigned BLINK_W = cnt_width(BLINK_COUNT);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(BLINK_TICKS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_COUNT - 1);

    if (PRESCALE < 1 || BLINK_TICKS < 1 || BLINK_COUNT < 1) begin : g_bad_count
        $error("status_led_driver: PRESCALE, BLINK_TICKS and BLINK_COUNT must be at least 1");
    end
    if (PWM_DUTY > (1 << PWM_CNT_W)) begin : g_bad_duty
        $error("status_led_driver: PWM_DUTY must be 0..16");
    end

    led_state_t        state;
    logic              status_q;
    logic [TICK_W-1:0] tick_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic              change;
    logic              tick;
    logic              idle_led;

    assign change = (status != status_q);

    // A change restarts the tick period so every half-period is full length.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .clear (reset || change),
        .tick  (tick)
    );

`ifdef STATUS_LED_PWM_EN
    logic [PWM_CNT_W-1:0] pwm_cnt;

    // Free-running PWM phase counter for the idle-on level.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    assign idle_led = status_q && ({1'b0, pwm_cnt} < (PWM_CNT_W + 1)'(PWM_DUTY));
`else
    assign idle_led = status_q;
`endif

    // Blink FSM; led and busy are registered alongside the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            status_q  <= status;
            tick_cnt  <= '0;
            blink_cnt <= '0;
            led       <= 1'b0;
            busy      <= 1'b0;
        end else if (change) begin
            // Takes priority over every state, including the OFF exit.
            state     <= ST_ON;
            status_q  <= status;
            tick_cnt  <= '0;
            blink_cnt <= '0;
            led       <= 1'b1;
            busy      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    led  <= idle_led;
                    busy <= 1'b0;
                end
                ST_ON: begin
                    if (tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            state    <= ST_OFF;
                            led      <= 1'b0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                ST_OFF: begin
                    if (tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (blink_cnt == BLINK_LAST) begin
                                blink_cnt <= '0;
                                state     <= ST_IDLE;
                                led       <= idle_led;
                                busy      <= 1'b0;
                            end else begin
                                blink_cnt <= blink_cnt + 1'b1;
                                state     <= ST_ON;
                                led       <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    led   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_status_led_driver.sv
// Directed testbench for status_led_driver (PRESCALE=4, BLINK_TICKS=2,
// BLINK_COUNT=2, PWM_DUTY=4). Cycle k means the value after clock edge k.
module tb_status_led_driver;

    localparam int unsigned P_PRESCALE = 4;
    localparam int unsigned P_TICKS    = 2;
    localparam int unsigned P_COUNT    = 2;
    localparam int unsigned P_DUTY     = 4;

    logic clk = 1'b0;
    logic reset;
    logic status;
    logic led;
    logic busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    status_led_driver #(
        .PRESCALE    (P_PRESCALE),
        .BLINK_TICKS (P_TICKS),
        .BLINK_COUNT (P_COUNT),
        .PWM_DUTY    (P_DUTY)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .status (status),
        .led    (led),
        .busy   (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset(input logic s);
        reset  = 1'b1;
        status = s;
        step();
        step();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        status = 1'b0;
        step();
        checks++;
        if (led !== 1'b0) begin errors++; $display("FAIL reset_led0: got %b want 0", led); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %b want 0", busy); end
        status = 1'b1;
        step();
        checks++;
        if (led !== 1'b0) begin errors++; $display("FAIL reset_led1: got %b want 0", led); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b want 0", busy); end
        reset = 1'b0;
        cyc   = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL release_busy c%0d: got %b want 0", k, busy); end
`ifndef STATUS_LED_PWM_EN
            checks++;
            if (led !== 1'b1) begin errors++; $display("FAIL release_led c%0d: got %b want 1", k, led); end
`endif
        end
    endtask

    task automatic test_blink();
        logic el, eb;
        do_reset(1'b0);
        goto(10);
        status = 1'b1;
        for (int k = 11; k <= 50; k++) begin
            step();
            el = (k <= 18) || (k >= 27 && k <= 34) || (k >= 43);
            eb = (k <= 42);
`ifdef STATUS_LED_PWM_EN
            if (k < 43) begin
`else
            begin
`endif
                checks++;
                if (led !== el) begin errors++; $display("FAIL blink_led c%0d: got %b want %b", k, led, el); end
            end
            checks++;
            if (busy !== eb) begin errors++; $display("FAIL blink_busy c%0d: got %b want %b", k, busy, eb); end
        end
    endtask

    task automatic test_restart();
        logic el, eb;
        do_reset(1'b0);
        goto(10);
        status = 1'b1;
        goto(20);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL restart_pre_busy: got %b want 1", busy); end
        status = 1'b0;
        for (int k = 21; k <= 60; k++) begin
            step();
            el = (k <= 28) || (k >= 37 && k <= 44);
            eb = (k <= 52);
            checks++;
            if (led !== el) begin errors++; $display("FAIL restart_led c%0d: got %b want %b", k, led, el); end
            checks++;
            if (busy !== eb) begin errors++; $display("FAIL restart_busy c%0d: got %b want %b", k, busy, eb); end
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1'b0);
        goto(10);
        status = 1'b1;
        goto(15);
        checks++;
        if (led !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: got led=%b busy=%b want 1 1", led, busy);
        end
        reset = 1'b1;
        step();
        checks++;
        if (led !== 1'b0) begin errors++; $display("FAIL midreset_led: got %b want 0", led); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        reset = 1'b0;
        for (int k = 17; k <= 36; k++) begin
            step();
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL midreset_after_busy c%0d: got %b want 0", k, busy); end
`ifndef STATUS_LED_PWM_EN
            checks++;
            if (led !== 1'b1) begin errors++; $display("FAIL midreset_after_led c%0d: got %b want 1", k, led); end
`endif
        end
    endtask

    task automatic test_exit_collision();
        logic el, eb;
        do_reset(1'b0);
        goto(10);
        status = 1'b1;
        goto(42);
        checks++;
        if (led !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL collide_pre: got led=%b busy=%b want 0 1", led, busy);
        end
        status = 1'b0;
        for (int k = 43; k <= 80; k++) begin
            step();
            el = (k <= 50) || (k >= 59 && k <= 66);
            eb = (k <= 74);
            checks++;
            if (led !== el) begin errors++; $display("FAIL collide_led c%0d: got %b want %b", k, led, el); end
            checks++;
            if (busy !== eb) begin errors++; $display("FAIL collide_busy c%0d: got %b want %b", k, busy, eb); end
        end
    endtask

`ifdef STATUS_LED_PWM_EN
    task automatic test_pwm();
        int highs;
        highs = 0;
        do_reset(1'b1);
        goto(5);
        for (int k = 0; k < 32; k++) begin
            step();
            if (led === 1'b1) highs++;
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL pwm_busy c%0d: got %b want 0", cyc, busy); end
        end
        checks++;
        if (highs !== int'(2 * P_DUTY)) begin
            errors++; $display("FAIL pwm_duty: got %0d high of 32 want %0d", highs, 2 * P_DUTY);
        end
    endtask
`endif

    initial begin
        reset  = 1'b1;
        status = 1'b0;
        test_reset();
        test_blink();
        test_restart();
        test_mid_reset();
        test_exit_collision();
`ifdef STATUS_LED_PWM_EN
        test_pwm();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
